// File: rtl/rvfi_seq_pkg.sv
// rvfi_seq_pkg: shared types for the RVFI retire sequencer.
//   XLEN         data/pc width of a completion record
//   rvfi_rec_t   one completion record as carried from writeback to the trace
//   REC_ZERO     all-zero record driven on idle channels
//   rec_retire_view() applies the rd_addr==0 -> rd_wdata==0 rule at emit time
package rvfi_seq_pkg;

    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic [31:0]     insn;
        logic            trap;
        logic [XLEN-1:0] pc_rdata;
        logic [XLEN-1:0] pc_wdata;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rd_wdata;
    } rvfi_rec_t;

    localparam rvfi_rec_t REC_ZERO = '0;

    // x0 is hardwired: whatever the core reported, the trace shows 0.
    function automatic rvfi_rec_t rec_retire_view(input rvfi_rec_t r);
        rvfi_rec_t v;
        v = r;
        if (r.rd_addr == 5'd0) begin
            v.rd_wdata = '0;
        end
        return v;
    endfunction

endpackage

// File: rtl/rvfi_seq_slots.sv
// rvfi_seq_slots: reorder storage for the retire sequencer.
//   DEPTH records plus a busy bit per slot; one write port, NRET read ports
//   at head, head+1, ... head+NRET-1 (mod DEPTH).
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset (clears busy)
//   wr_en          write record wr_rec into slot wr_tag and mark it busy
//   wr_tag         slot index for the write
//   wr_rec         record to store
//   clr_mask       slots to free this edge (retired slots)
//   head           oldest slot in program order
//   busy           per-slot occupancy
//   rd_rec         records at head+i, i = 0..NRET-1
module rvfi_seq_slots
    import rvfi_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned NRET  = 1,
    parameter int unsigned TAG_W = $clog2(DEPTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [TAG_W-1:0]        wr_tag,
    input  rvfi_rec_t               wr_rec,
    input  logic [DEPTH-1:0]        clr_mask,
    input  logic [TAG_W-1:0]        head,
    output logic [DEPTH-1:0]        busy,
    output rvfi_rec_t [NRET-1:0]    rd_rec
);

    rvfi_rec_t        mem [DEPTH];
    logic [DEPTH-1:0] set_mask;

    always_comb begin
        set_mask = '0;
        if (wr_en) begin
            set_mask[wr_tag] = 1'b1;
        end
    end

    // Writes only target free slots and clears only target busy ones, so the
    // two masks never overlap on the same slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end

    // Record payload needs no reset: busy gates every use of it.
    always_ff @(posedge clock) begin
        if (wr_en && !reset) begin
            mem[wr_tag] <= wr_rec;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NRET; i++) begin
            rd_rec[i] = mem[head + TAG_W'(i)];
        end
    end

endmodule

// File: rtl/rvfi_retire_sequencer.sv
// rvfi_retire_sequencer: reorders out-of-order completion records from the
// core back into program order and emits them on NRET RVFI channels with a
// monotonically increasing rvfi_order.
// Configuration macro:
//   RVFI_SEQ_BYPASS_EN  when defined, a record handshaked into the free head
//                       slot retires in the same cycle's select (no storage
//                       write), cutting latency from 2 cycles to 1.
// Ports:
//   clock, reset     rising-edge clock, synchronous active-high reset
//   in_valid/ready   completion record handshake; ready = slot in_tag free
//   in_tag           program-order slot of the record
//   in_insn .. in_rd_wdata   completion record fields
//   rvfi_valid       per-channel retire strobe (channel 0 = oldest)
//   rvfi_order       per-channel 64-bit order, packed NRET-wide
//   rvfi_insn .. rvfi_rd_wdata  per-channel packed record fields
//   seq_err          sticky: record offered to a busy slot
module rvfi_retire_sequencer
    import rvfi_seq_pkg::*;
#(
    parameter int unsigned NRET  = 1,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TAG_W = $clog2(DEPTH),
    parameter int unsigned XLEN  = rvfi_seq_pkg::XLEN
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TAG_W-1:0]       in_tag,
    input  logic [31:0]            in_insn,
    input  logic                   in_trap,
    input  logic [XLEN-1:0]        in_pc_rdata,
    input  logic [XLEN-1:0]        in_pc_wdata,
    input  logic [4:0]             in_rs1_addr,
    input  logic [4:0]             in_rs2_addr,
    input  logic [4:0]             in_rd_addr,
    input  logic [XLEN-1:0]        in_rd_wdata,
    output logic [NRET-1:0]        rvfi_valid,
    output logic [64*NRET-1:0]     rvfi_order,
    output logic [32*NRET-1:0]     rvfi_insn,
    output logic [NRET-1:0]        rvfi_trap,
    output logic [XLEN*NRET-1:0]   rvfi_pc_rdata,
    output logic [XLEN*NRET-1:0]   rvfi_pc_wdata,
    output logic [5*NRET-1:0]      rvfi_rs1_addr,
    output logic [5*NRET-1:0]      rvfi_rs2_addr,
    output logic [5*NRET-1:0]      rvfi_rd_addr,
    output logic [XLEN*NRET-1:0]   rvfi_rd_wdata,
    output logic                   seq_err
);

`ifdef RVFI_SEQ_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    localparam int unsigned KW = $clog2(NRET + 1);

    if (XLEN != rvfi_seq_pkg::XLEN) begin : g_xlen_chk
        $error("XLEN must match rvfi_seq_pkg::XLEN");
    end
    if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < NRET || DEPTH < 2) begin : g_depth_chk
        $error("DEPTH must be a power of two, >= 2 and >= NRET");
    end

    logic [TAG_W-1:0]       head;
    logic [63:0]            order_ctr;
    logic [DEPTH-1:0]       busy;
    logic [DEPTH-1:0]       clr_mask;
    rvfi_rec_t [NRET-1:0]   rd_rec;
    rvfi_rec_t [NRET-1:0]   chan_rec;
    rvfi_rec_t              in_rec;
    logic                   hs;
    logic                   byp;
    logic                   wr_en;
    logic [NRET-1:0]        take;
    logic [KW-1:0]          k;

    logic [NRET-1:0]        out_valid;
    logic [NRET-1:0][63:0]  out_order;
    rvfi_rec_t [NRET-1:0]   out_rec;

    always_comb begin
        in_rec          = REC_ZERO;
        in_rec.insn     = in_insn;
        in_rec.trap     = in_trap;
        in_rec.pc_rdata = in_pc_rdata;
        in_rec.pc_wdata = in_pc_wdata;
        in_rec.rs1_addr = in_rs1_addr;
        in_rec.rs2_addr = in_rs2_addr;
        in_rec.rd_addr  = in_rd_addr;
        in_rec.rd_wdata = in_rd_wdata;
    end

    // A busy tag is never ready, so a duplicate can never overwrite a slot.
    assign in_ready = !reset && !busy[in_tag];
    assign hs       = in_valid && in_ready;
    assign byp      = BYPASS_EN && hs && (in_tag == head);
    assign wr_en    = hs && !byp;

    rvfi_seq_slots #(
        .DEPTH (DEPTH),
        .NRET  (NRET),
        .TAG_W (TAG_W)
    ) u_slots (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_tag   (in_tag),
        .wr_rec   (in_rec),
        .clr_mask (clr_mask),
        .head     (head),
        .busy     (busy),
        .rd_rec   (rd_rec)
    );

    // Select: take the unbroken run of busy slots starting at head, capped at
    // NRET. The first hole stops the run even if younger slots are busy.
    always_comb begin
        logic             run;
        logic [TAG_W-1:0] idx;
        take     = '0;
        k        = '0;
        clr_mask = '0;
        chan_rec = rd_rec;
        run      = 1'b1;
        idx      = '0;
        if (byp) begin
            chan_rec[0] = in_rec;
        end
        for (int unsigned i = 0; i < NRET; i++) begin
            idx = head + TAG_W'(i);
            run = run && (busy[idx] || (byp && i == 0));
            take[i] = run;
            if (run) begin
                k = k + KW'(1);
                clr_mask[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head      <= '0;
            order_ctr <= '0;
            seq_err   <= 1'b0;
            out_valid <= '0;
            out_order <= '0;
            out_rec   <= '0;
        end else begin
            head      <= head + TAG_W'(k);
            order_ctr <= order_ctr + 64'(k);
            if (in_valid && busy[in_tag]) begin
                seq_err <= 1'b1;
            end
            for (int unsigned i = 0; i < NRET; i++) begin
                out_valid[i] <= take[i];
                out_order[i] <= take[i] ? order_ctr + 64'(i) : 64'd0;
                out_rec[i]   <= take[i] ? rec_retire_view(chan_rec[i]) : REC_ZERO;
            end
        end
    end

    assign rvfi_valid = out_valid;
    assign rvfi_order = out_order;

    for (genvar i = 0; i < NRET; i++) begin : g_ch
        assign rvfi_insn[32*i +: 32]       = out_rec[i].insn;
        assign rvfi_trap[i]                = out_rec[i].trap;
        assign rvfi_pc_rdata[XLEN*i +: XLEN] = out_rec[i].pc_rdata;
        assign rvfi_pc_wdata[XLEN*i +: XLEN] = out_rec[i].pc_wdata;
        assign rvfi_rs1_addr[5*i +: 5]     = out_rec[i].rs1_addr;
        assign rvfi_rs2_addr[5*i +: 5]     = out_rec[i].rs2_addr;
        assign rvfi_rd_addr[5*i +: 5]      = out_rec[i].rd_addr;
        assign rvfi_rd_wdata[XLEN*i +: XLEN] = out_rec[i].rd_wdata;
    end

endmodule

// File: tb/tb_rvfi_retire_sequencer.sv
// Directed bench for rvfi_retire_sequencer: one NRET=1 instance (a_*) and one
// NRET=2 instance (b_*), both DEPTH=8, sharing clock, reset and record data.
module tb_rvfi_retire_sequencer;

`ifdef RVFI_SEQ_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // shared record data
    logic [31:0] d_insn = '0, d_pc = '0, d_pcw = '0, d_wd = '0;
    logic        d_trap = 1'b0;
    logic [4:0]  d_rs1 = '0, d_rs2 = '0, d_rd = '0;

    logic        a_valid = 1'b0, a_ready;
    logic [2:0]  a_tag = '0;
    logic [0:0]  a_rv_valid, a_rv_trap;
    logic [63:0] a_order;
    logic [31:0] a_rv_insn, a_rv_pc, a_rv_pcw, a_rv_wd;
    logic [4:0]  a_rv_rs1, a_rv_rs2, a_rv_rd;
    logic        a_err;

    logic         b_valid = 1'b0, b_ready;
    logic [2:0]   b_tag = '0;
    logic [1:0]   b_rv_valid, b_rv_trap;
    logic [127:0] b_order;
    logic [63:0]  b_rv_insn, b_rv_pc, b_rv_pcw, b_rv_wd;
    logic [9:0]   b_rv_rs1, b_rv_rs2, b_rv_rd;
    logic         b_err;

    rvfi_retire_sequencer #(.NRET(1), .DEPTH(8)) dut_a (
        .clock(clock), .reset(reset), .in_valid(a_valid), .in_ready(a_ready),
        .in_tag(a_tag), .in_insn(d_insn), .in_trap(d_trap), .in_pc_rdata(d_pc),
        .in_pc_wdata(d_pcw), .in_rs1_addr(d_rs1), .in_rs2_addr(d_rs2),
        .in_rd_addr(d_rd), .in_rd_wdata(d_wd),
        .rvfi_valid(a_rv_valid), .rvfi_order(a_order), .rvfi_insn(a_rv_insn),
        .rvfi_trap(a_rv_trap), .rvfi_pc_rdata(a_rv_pc), .rvfi_pc_wdata(a_rv_pcw),
        .rvfi_rs1_addr(a_rv_rs1), .rvfi_rs2_addr(a_rv_rs2), .rvfi_rd_addr(a_rv_rd),
        .rvfi_rd_wdata(a_rv_wd), .seq_err(a_err)
    );

    rvfi_retire_sequencer #(.NRET(2), .DEPTH(8)) dut_b (
        .clock(clock), .reset(reset), .in_valid(b_valid), .in_ready(b_ready),
        .in_tag(b_tag), .in_insn(d_insn), .in_trap(d_trap), .in_pc_rdata(d_pc),
        .in_pc_wdata(d_pcw), .in_rs1_addr(d_rs1), .in_rs2_addr(d_rs2),
        .in_rd_addr(d_rd), .in_rd_wdata(d_wd),
        .rvfi_valid(b_rv_valid), .rvfi_order(b_order), .rvfi_insn(b_rv_insn),
        .rvfi_trap(b_rv_trap), .rvfi_pc_rdata(b_rv_pc), .rvfi_pc_wdata(b_rv_pcw),
        .rvfi_rs1_addr(b_rv_rs1), .rvfi_rs2_addr(b_rv_rs2), .rvfi_rd_addr(b_rv_rd),
        .rvfi_rd_wdata(b_rv_wd), .seq_err(b_err)
    );

    typedef struct {
        logic [63:0] order;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd;
        logic [31:0] wd;
        int          ch;
        int          cyc;
    } ev_t;

    ev_t qa[$];
    ev_t qb[$];

    always @(negedge clock) begin
        ev_t e;
        if (a_rv_valid[0]) begin
            e.order = a_order; e.pc = a_rv_pc; e.insn = a_rv_insn;
            e.rd = a_rv_rd; e.wd = a_rv_wd; e.ch = 0; e.cyc = cyc;
            qa.push_back(e);
        end
        for (int i = 0; i < 2; i++) begin
            if (b_rv_valid[i]) begin
                e.order = b_order[64*i +: 64]; e.pc = b_rv_pc[32*i +: 32];
                e.insn = b_rv_insn[32*i +: 32]; e.rd = b_rv_rd[5*i +: 5];
                e.wd = b_rv_wd[32*i +: 32]; e.ch = i; e.cyc = cyc;
                qb.push_back(e);
            end
        end
    end

    int n_chk = 0;
    int n_bad = 0;
    int hs_cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        qa.delete(); qb.delete();
        #1;
    endtask

    task automatic load_data(input logic [2:0] tag, input logic [31:0] pc,
                             input logic [4:0] rd, input logic [31:0] wd);
        d_pc = pc; d_pcw = pc + 32'd4;
        d_insn = 32'h13 | ({29'd0, tag} << 7);
        d_trap = 1'b0; d_rs1 = 5'd1; d_rs2 = 5'd2; d_rd = rd; d_wd = wd;
    endtask

    task automatic send_a(input logic [2:0] tag, input logic [31:0] pc,
                          input logic [4:0] rd, input logic [31:0] wd);
        load_data(tag, pc, rd, wd);
        a_tag = tag; a_valid = 1'b1;
        @(posedge clock); #1;
        hs_cyc = cyc; a_valid = 1'b0;
    endtask

    task automatic send_b(input logic [2:0] tag, input logic [31:0] pc);
        load_data(tag, pc, 5'd3, pc);
        b_tag = tag; b_valid = 1'b1;
        @(posedge clock); #1;
        hs_cyc = cyc; b_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Bounded wait for n monitored retires on instance a (0) or b (1).
    task automatic wait_q(input string tag, input int which, input int n, input int budget);
        int t = 0;
        while (((which == 0) ? qa.size() : qb.size()) < n && t < budget) begin
            @(posedge clock); #1;
            t++;
        end
        @(posedge clock); #1;
        check(tag, ((which == 0) ? qa.size() : qb.size()), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h;

        // reset state
        do_reset();
        check("rst_valid_a", a_rv_valid, 0);
        check("rst_order_a", a_order, 0);
        check("rst_err_a", a_err, 0);
        check("rst_wd_a", a_rv_wd, 0);
        check("rst_ready_a", a_ready, 1);
        check("rst_valid_b", b_rv_valid, 0);

        // 1: in-order tags 0,1,2, one per cycle
        send_a(3'd0, 32'h100, 5'd1, 32'h11);
        h = hs_cyc;
        send_a(3'd1, 32'h104, 5'd1, 32'h12);
        send_a(3'd2, 32'h108, 5'd1, 32'h13);
        wait_q("t1_count", 0, 3, 10);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t1_order%0d", i), qa[i].order, i);
            check($sformatf("t1_pc%0d", i), qa[i].pc, 32'h100 + 32'(4 * i));
            check($sformatf("t1_cyc%0d", i), qa[i].cyc, h + LAT + i);
        end
        check("t1_insn1", qa[1].insn, 32'h93);

        // 2: NRET=2, tags 2,1,0
        do_reset();
        send_b(3'd2, 32'h208);
        send_b(3'd1, 32'h204);
        send_b(3'd0, 32'h200);
        h = hs_cyc;
        wait_q("t2_count", 1, 3, 10);
        check("t2_o0", qb[0].order, 0);
        check("t2_ch0", qb[0].ch, 0);
        check("t2_pc0", qb[0].pc, 32'h200);
        check("t2_cyc0", qb[0].cyc, h + LAT);
        check("t2_o1", qb[1].order, 1);
        check("t2_ch1", qb[1].ch, 1);
        check("t2_pc1", qb[1].pc, 32'h204);
        check("t2_cyc1", qb[1].cyc, h + LAT);
        check("t2_o2", qb[2].order, 2);
        check("t2_ch2", qb[2].ch, 0);
        check("t2_pc2", qb[2].pc, 32'h208);
        check("t2_cyc2", qb[2].cyc, h + LAT + 1);

        // 3: hole at head, fill 1..7, then tag 0 releases all 8, then wrap
        do_reset();
        for (int t = 1; t < 8; t++) begin
            send_a(3'(t), 32'h300 + 32'(4 * t), 5'd4, 32'(t));
        end
        idle(3);
        check("t3_hold", qa.size(), 0);
        for (int t = 0; t < 8; t++) begin
            a_tag = 3'(t);
            #1 check($sformatf("t3_ready%0d", t), a_ready, (t == 0) ? 1 : 0);
        end
        send_a(3'd0, 32'h300, 5'd4, 32'd0);
        h = hs_cyc;
`ifndef RVFI_SEQ_BYPASS_EN
        a_tag = 3'd0;
        #1 check("t3_full_ready0", a_ready, 0);
        a_tag = 3'd5;
        #1 check("t3_full_ready5", a_ready, 0);
`endif
        wait_q("t3_count", 0, 8, 20);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_order%0d", i), qa[i].order, i);
            check($sformatf("t3_pc%0d", i), qa[i].pc, 32'h300 + 32'(4 * i));
            check($sformatf("t3_cyc%0d", i), qa[i].cyc, h + LAT + i);
        end
        send_a(3'd0, 32'h400, 5'd4, 32'd9);
        wait_q("t3_wrap_count", 0, 9, 10);
        check("t3_wrap_order", qa[8].order, 8);
        check("t3_wrap_pc", qa[8].pc, 32'h400);

        // 4: duplicate tag 3 is rejected and sets sticky seq_err
        do_reset();
        send_a(3'd3, 32'h500, 5'd6, 32'h55);
        load_data(3'd3, 32'h5f0, 5'd6, 32'h66);
        a_tag = 3'd3; a_valid = 1'b1;
        #1 check("t4_ready_dup", a_ready, 0);
        @(posedge clock); #1;
        a_valid = 1'b0;
        check("t4_err_set", a_err, 1);
        idle(3);
        check("t4_err_sticky", a_err, 1);
        check("t4_no_retire", qa.size(), 0);
        send_a(3'd0, 32'h5c0, 5'd6, 32'd0);
        send_a(3'd1, 32'h5c4, 5'd6, 32'd1);
        send_a(3'd2, 32'h5c8, 5'd6, 32'd2);
        wait_q("t4_count", 0, 4, 12);
        check("t4_keep_pc", qa[3].pc, 32'h500);
        check("t4_err_still", a_err, 1);
        do_reset();
        check("t4_err_clear", a_err, 0);

        // 5: rd_addr==0 zeroes rd_wdata; reset with 4 busy slots
        send_a(3'd0, 32'h600, 5'd0, 32'hDEADBEEF);
        send_a(3'd1, 32'h604, 5'd5, 32'h1234);
        wait_q("t5_count", 0, 2, 10);
        check("t5_rd0", qa[0].rd, 0);
        check("t5_wd0", qa[0].wd, 0);
        check("t5_wd1", qa[1].wd, 32'h1234);
        for (int t = 4; t < 8; t++) begin
            send_a(3'(t), 32'h640 + 32'(4 * t), 5'd7, 32'(t));
        end
        idle(2);
        check("t5_hold", qa.size(), 2);
        reset = 1'b1;
        @(posedge clock); #1;
        check("t5_rst_valid", a_rv_valid, 0);
        check("t5_rst_order", a_order, 0);
        check("t5_rst_pc", a_rv_pc, 0);
        check("t5_rst_wd", a_rv_wd, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        a_tag = 3'd4;
        #1 check("t5_freed_ready", a_ready, 1);
        send_a(3'd0, 32'h700, 5'd7, 32'h77);
        wait_q("t5_post_count", 0, 3, 10);
        check("t5_post_order", qa[2].order, 0);
        check("t5_post_pc", qa[2].pc, 32'h700);
        idle(4);
        check("t5_no_stale", qa.size(), 3);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
